// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, S-box table, GF(2^8) doubling and legal key-size constants.
package aes_pkg;

    typedef logic [31:0] word_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    localparam int NK_128 = 4;
    localparam int NR_128 = 10;
    localparam int NK_192 = 6;
    localparam int NR_192 = 12;
    localparam int NK_256 = 8;
    localparam int NR_256 = 14;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic bit legal_pair(input int nk, input int nr);
        return (nk == NK_128 && nr == NR_128) || (nk == NK_192 && nr == NR_192) ||
               (nk == NK_256 && nr == NR_256);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES S-box byte substitution.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    assign y = SBOX[a];
endmodule

// File: rtl/key_expand_seq.sv
// key_expand_seq: iterative AES key expansion, one schedule word per clock, round keys readable by index.
// Optional KEYEXP_ZEROIZE_EN: clears schedule words at start and hides rd_key until keys_valid.
module key_expand_seq
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [0:Nk*32-1]   key,
    output logic               busy,
    output logic               done,
    output logic               keys_valid,
    input  logic [3:0]         rd_idx,
    output logic [0:127]       rd_key
);
    localparam int Nw = 4 * (Nr + 1);
    localparam logic [5:0] NK6 = 6'(Nk);
    localparam logic [5:0] LAST = 6'(Nw - 1);
    localparam logic [2:0] JMAX = 3'(Nk - 1);
    localparam logic [3:0] NR4 = 4'(Nr);

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t     state;
    word_t      w [Nw];
    logic [5:0] i;
    logic [2:0] j;
    logic [7:0] rcon;
    word_t      prev;
    word_t      sub_in;
    word_t      sub;
    word_t      temp;
    word_t      nxt;
    logic [5:0] base;

    if (!legal_pair(Nk, Nr)) begin : g_bad_cfg
        $error("key_expand_seq: Nk/Nr is not a legal AES pair");
    end

    // j tracks i mod Nk so no divider is needed
    assign prev   = w[i - 6'd1];
    assign sub_in = (j == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .y(sub[8*b +: 8]));
    end

    assign temp = (j == 3'd0) ? sub ^ {rcon, 24'h0} : (Nk > 6 && j == 3'd4) ? sub : prev;
    assign nxt  = w[i - NK6] ^ temp;
    assign base = {rd_idx, 2'b00};

`ifdef KEYEXP_ZEROIZE_EN
    assign rd_key = (rd_idx > NR4 || !keys_valid) ? 128'h0 :
                    {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
`else
    assign rd_key = (rd_idx > NR4) ? 128'h0 :
                    {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
`endif

    // Expansion FSM: load key words on start, then derive one schedule word per edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            i          <= '0;
            j          <= '0;
            rcon       <= RCON_INIT;
            for (int k = 0; k < Nw; k++) w[k] <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    for (int k = 0; k < Nk; k++) w[k] <= key[32*k +: 32];
`ifdef KEYEXP_ZEROIZE_EN
                    for (int k = Nk; k < Nw; k++) w[k] <= '0;
`endif
                    i          <= NK6;
                    j          <= '0;
                    rcon       <= RCON_INIT;
                    keys_valid <= 1'b0;
                    busy       <= 1'b1;
                    state      <= EXPAND;
                end
            end else begin
                w[i] <= nxt;
                i    <= i + 6'd1;
                j    <= (j == JMAX) ? 3'd0 : j + 3'd1;
                if (j == 3'd0) rcon <= xtime(rcon);
                if (i == LAST) begin
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    keys_valid <= 1'b1;
                    state      <= IDLE;
                end
            end
        end
    end

endmodule
